// File: rtl/fpu_exu_seq_if.sv
// Handshake and data bundle between the FP execute sequencer and its environment.
// master = environment side (issues instructions, hosts the core), slave = sequencer.
interface fpu_exu_seq_if #(
  parameter int FPLEN = 16,
  parameter int XLEN  = 32,
  parameter int NOPS  = 24,
  parameter int TAG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [NOPS-1:0]   in_op;
  logic [2:0]        in_rnd;
  logic [2:0]        in_ctrl;
  logic [TAG_W-1:0]  in_tag;
  logic [XLEN-1:0]   gpr_rs1;
  logic [FPLEN-1:0]  fs1;
  logic [FPLEN-1:0]  fs2;
  logic [FPLEN-1:0]  fs3;

  logic              core_req;
  logic [NOPS-1:0]   core_op;
  logic [2:0]        core_rnd;
  logic [FPLEN-1:0]  core_a;
  logic [FPLEN-1:0]  core_b;
  logic [FPLEN-1:0]  core_c;
  logic [XLEN-1:0]   core_int;
  logic              core_flush;
  logic              core_done;
  logic [FPLEN-1:0]  core_res;
  logic [XLEN-1:0]   core_res_rd;
  logic [4:0]        core_flags;

  logic              fpr_wb_valid;
  logic              fpr_wb_ready;
  logic              gpr_wb_valid;
  logic              gpr_wb_ready;
  logic [XLEN-1:0]   wb_data;
  logic [TAG_W-1:0]  wb_tag;

  logic [4:0]        sflags_acc;
  logic              sflags_clr;
  logic              illegal_op;
  logic              timeout_err;

  modport master (
    output in_valid, in_op, in_rnd, in_ctrl, in_tag, gpr_rs1, fs1, fs2, fs3,
    output core_done, core_res, core_res_rd, core_flags,
    output fpr_wb_ready, gpr_wb_ready, sflags_clr,
    input  in_ready, core_req, core_op, core_rnd, core_a, core_b, core_c, core_int,
    input  core_flush, fpr_wb_valid, gpr_wb_valid, wb_data, wb_tag,
    input  sflags_acc, illegal_op, timeout_err
  );

  modport slave (
    input  in_valid, in_op, in_rnd, in_ctrl, in_tag, gpr_rs1, fs1, fs2, fs3,
    input  core_done, core_res, core_res_rd, core_flags,
    input  fpr_wb_ready, gpr_wb_ready, sflags_clr,
    output in_ready, core_req, core_op, core_rnd, core_a, core_b, core_c, core_int,
    output core_flush, fpr_wb_valid, gpr_wb_valid, wb_data, wb_tag,
    output sflags_acc, illegal_op, timeout_err
  );
endinterface

// File: rtl/fpu_exu_seq.sv
// FP execute sequencer: accepts one instruction, issues it to a variable-latency
// FPU core, guards it with a watchdog and routes the result to FPR or GPR writeback.
module fpu_exu_seq #(
  parameter int FPLEN   = 16,
  parameter int XLEN    = 32,
  parameter int NOPS    = 24,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_l,
  fpu_exu_seq_if.slave bus
);
  localparam int NFUNC = 22;
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Ops whose result is integer: bits 8,9,10,11,14,21.
  localparam logic [NFUNC-1:0] GPR_CLASS = 22'h20_4F00;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_WB} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              core_req_reg;
  logic              core_flush_reg;
  logic [NOPS-1:0]   core_op_reg;
  logic [2:0]        core_rnd_reg;
  logic [FPLEN-1:0]  core_a_reg;
  logic [FPLEN-1:0]  core_b_reg;
  logic [FPLEN-1:0]  core_c_reg;
  logic [XLEN-1:0]   core_int_reg;
  logic              fpr_wb_valid_reg;
  logic              gpr_wb_valid_reg;
  logic [XLEN-1:0]   wb_data_reg;
  logic [TAG_W-1:0]  wb_tag_reg;
  logic [4:0]        sflags_reg;
  logic [4:0]        sflags_next;
  logic              illegal_reg;
  logic              timeout_reg;
  logic [WD_W-1:0]   wd_reg;

  logic [4:0]        func_cnt;
  logic              op_legal;
  logic [NFUNC-1:0]  gpr_hit;
  logic              gpr_class;
  logic              done_capture;
  logic              wb_handshake;
  logic [FPLEN-1:0]  opa_next;
  logic [FPLEN-1:0]  opb_next;
  logic [FPLEN-1:0]  opc_next;
  logic [XLEN-1:0]   opi_next;

  // Legal means exactly one function bit; modifier bits are not counted.
  always_comb begin
    func_cnt = '0;
    for (int i = 0; i < NFUNC; i++) begin
      func_cnt = func_cnt + 5'(bus.in_op[i]);
    end
  end
  assign op_legal = (func_cnt == 5'd1);

  for (genvar gi = 0; gi < NFUNC; gi++) begin : g_cls
    assign gpr_hit[gi] = core_op_reg[gi] & GPR_CLASS[gi];
  end
  assign gpr_class = |gpr_hit;

  always_comb begin
    opa_next = bus.in_ctrl[0] ? bus.fs1 : bus.gpr_rs1[FPLEN-1:0];
    opi_next = bus.in_ctrl[0] ? '0 : bus.gpr_rs1;
    opb_next = bus.in_ctrl[1] ? bus.fs2 : '0;
    opc_next = bus.in_ctrl[2] ? bus.fs3 : '0;
  end

  // A zero-latency core may answer in the issue cycle itself.
  assign done_capture = bus.core_done && ((state_reg == S_ISSUE) || (state_reg == S_BUSY));
  assign wb_handshake = (fpr_wb_valid_reg && bus.fpr_wb_ready) ||
                        (gpr_wb_valid_reg && bus.gpr_wb_ready);
  // A set arriving with a clear survives the clear.
  assign sflags_next  = (bus.sflags_clr ? 5'd0 : sflags_reg) |
                        (done_capture ? bus.core_flags : 5'd0);

  always_ff @(posedge clk or posedge rst_l) begin
    if (rst_l) begin
      state_reg        <= S_IDLE;
      in_ready_reg     <= 1'b0;
      core_req_reg     <= 1'b0;
      core_flush_reg   <= 1'b0;
      core_op_reg      <= '0;
      core_rnd_reg     <= '0;
      core_a_reg       <= '0;
      core_b_reg       <= '0;
      core_c_reg       <= '0;
      core_int_reg     <= '0;
      fpr_wb_valid_reg <= 1'b0;
      gpr_wb_valid_reg <= 1'b0;
      wb_data_reg      <= '0;
      wb_tag_reg       <= '0;
      sflags_reg       <= '0;
      illegal_reg      <= 1'b0;
      timeout_reg      <= 1'b0;
      wd_reg           <= '0;
    end else begin
      core_req_reg   <= 1'b0;
      core_flush_reg <= 1'b0;
      illegal_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      sflags_reg     <= sflags_next;
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            if (op_legal) begin
              core_op_reg  <= bus.in_op;
              core_rnd_reg <= bus.in_rnd;
              core_a_reg   <= opa_next;
              core_b_reg   <= opb_next;
              core_c_reg   <= opc_next;
              core_int_reg <= opi_next;
              wb_tag_reg   <= bus.in_tag;
              core_req_reg <= 1'b1;
              in_ready_reg <= 1'b0;
              state_reg    <= S_ISSUE;
            end else begin
              illegal_reg  <= 1'b1;
            end
          end else begin
            in_ready_reg <= 1'b1;
          end
        end
        S_ISSUE, S_BUSY: begin
          if (bus.core_done) begin
            wb_data_reg      <= gpr_class ? bus.core_res_rd : XLEN'(bus.core_res);
            gpr_wb_valid_reg <= gpr_class;
            fpr_wb_valid_reg <= ~gpr_class;
            state_reg        <= S_WB;
          end else if (state_reg == S_ISSUE) begin
            wd_reg    <= '0;
            state_reg <= S_BUSY;
          end else if (wd_reg == WD_W'(TIMEOUT - 2)) begin
            // Flush becomes visible exactly TIMEOUT cycles after the issue pulse.
            core_flush_reg <= 1'b1;
            timeout_reg    <= 1'b1;
            in_ready_reg   <= 1'b1;
            state_reg      <= S_IDLE;
          end else begin
            wd_reg <= wd_reg + 1'b1;
          end
        end
        S_WB: begin
          if (wb_handshake) begin
            fpr_wb_valid_reg <= 1'b0;
            gpr_wb_valid_reg <= 1'b0;
            in_ready_reg     <= 1'b1;
            state_reg        <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.core_req     = core_req_reg;
  assign bus.core_op      = core_op_reg;
  assign bus.core_rnd     = core_rnd_reg;
  assign bus.core_a       = core_a_reg;
  assign bus.core_b       = core_b_reg;
  assign bus.core_c       = core_c_reg;
  assign bus.core_int     = core_int_reg;
  assign bus.core_flush   = core_flush_reg;
  assign bus.fpr_wb_valid = fpr_wb_valid_reg;
  assign bus.gpr_wb_valid = gpr_wb_valid_reg;
  assign bus.wb_data      = wb_data_reg;
  assign bus.wb_tag       = wb_tag_reg;
  assign bus.sflags_acc   = sflags_reg;
  assign bus.illegal_op   = illegal_reg;
  assign bus.timeout_err  = timeout_reg;
endmodule

// File: tb/tb_fpu_exu_seq.sv
// Randomised self-checking bench for fpu_exu_seq with a transaction-level model
// of operand selection, result routing and sticky flag accumulation.
module tb_fpu_exu_seq;
  localparam int FPLEN = 16, XLEN = 32, NOPS = 24, TAG_W = 5, TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst_l = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_flags = 5'd0;

  always #5 clk = ~clk;

  fpu_exu_seq_if #(.FPLEN(FPLEN), .XLEN(XLEN), .NOPS(NOPS), .TAG_W(TAG_W)) bus();

  fpu_exu_seq #(.FPLEN(FPLEN), .XLEN(XLEN), .NOPS(NOPS), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_op = '0; bus.in_rnd = '0; bus.in_ctrl = '0; bus.in_tag = '0;
    bus.gpr_rs1 = '0; bus.fs1 = '0; bus.fs2 = '0; bus.fs3 = '0;
    bus.core_done = 0; bus.core_res = '0; bus.core_res_rd = '0; bus.core_flags = '0;
    bus.fpr_wb_ready = 0; bus.gpr_wb_ready = 0; bus.sflags_clr = 0;
  endtask

  // One full transaction: accept, issue, core answer after lat cycles, writeback with stall.
  task automatic run_op(input logic [23:0] op, input logic [2:0] ctrl, input logic [2:0] rnd,
                        input logic [4:0] tag, input logic [31:0] gpr, input logic [15:0] f1,
                        input logic [15:0] f2, input logic [15:0] f3, input int lat,
                        input logic [15:0] res, input logic [31:0] res_rd, input logic [4:0] flg,
                        input int stall, input bit clr);
    int idx;
    bit is_gpr;
    logic [31:0] exp_data;
    logic [15:0] ea, eb, ec;
    logic [31:0] ei;
    idx = -1;
    for (int i = 0; i < 22; i++) if (op[i]) idx = i;
    is_gpr = (idx == 8 || idx == 9 || idx == 10 || idx == 11 || idx == 14 || idx == 21);
    exp_data = is_gpr ? res_rd : {16'h0, res};
    ea = ctrl[0] ? f1 : gpr[15:0];
    ei = ctrl[0] ? 32'h0 : gpr;
    eb = ctrl[1] ? f2 : 16'h0;
    ec = ctrl[2] ? f3 : 16'h0;

    bus.in_op = op; bus.in_ctrl = ctrl; bus.in_rnd = rnd; bus.in_tag = tag;
    bus.gpr_rs1 = gpr; bus.fs1 = f1; bus.fs2 = f2; bus.fs3 = f3; bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.core_req !== 1'b1 || bus.in_ready !== 1'b0 || bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL issue_pulse: req=%b ready=%b illegal=%b required 1 0 0", bus.core_req, bus.in_ready, bus.illegal_op);
    end
    checks++;
    if (bus.core_op !== op || bus.core_rnd !== rnd) begin
      failures++;
      $display("FAIL core_op: op=%h rnd=%h required %h %h", bus.core_op, bus.core_rnd, op, rnd);
    end
    checks++;
    if (bus.core_a !== ea || bus.core_b !== eb || bus.core_c !== ec || bus.core_int !== ei) begin
      failures++;
      $display("FAIL operands: a=%h b=%h c=%h int=%h required %h %h %h %h",
               bus.core_a, bus.core_b, bus.core_c, bus.core_int, ea, eb, ec, ei);
    end
    if (lat > 0) begin
      step();
      checks++;
      if (bus.core_req !== 1'b0) begin
        failures++;
        $display("FAIL req_one_cycle: req=%b required 0", bus.core_req);
      end
      for (int i = 1; i < lat; i++) step();
    end
    bus.core_done = 1; bus.core_res = res; bus.core_res_rd = res_rd; bus.core_flags = flg;
    bus.sflags_clr = clr;
    step();
    bus.core_done = 0; bus.sflags_clr = 0; bus.core_flags = '0;
    exp_flags = (clr ? 5'd0 : exp_flags) | flg;
    checks++;
    if (bus.fpr_wb_valid !== !is_gpr || bus.gpr_wb_valid !== is_gpr) begin
      failures++;
      $display("FAIL wb_route: fpr=%b gpr=%b required %b %b", bus.fpr_wb_valid, bus.gpr_wb_valid, !is_gpr, is_gpr);
    end
    checks++;
    if (bus.wb_data !== exp_data || bus.wb_tag !== tag) begin
      failures++;
      $display("FAIL wb_data: data=%h tag=%h required %h %h", bus.wb_data, bus.wb_tag, exp_data, tag);
    end
    checks++;
    if (bus.sflags_acc !== exp_flags) begin
      failures++;
      $display("FAIL sflags: got %b required %b", bus.sflags_acc, exp_flags);
    end
    // The non-matching ready is raised during the stall and must not release the result.
    bus.fpr_wb_ready = is_gpr; bus.gpr_wb_ready = !is_gpr;
    for (int s = 0; s < stall; s++) begin
      step();
      checks++;
      if (bus.fpr_wb_valid !== !is_gpr || bus.gpr_wb_valid !== is_gpr || bus.wb_data !== exp_data ||
          bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL wb_hold: fpr=%b gpr=%b data=%h ready=%b required %b %b %h 0",
                 bus.fpr_wb_valid, bus.gpr_wb_valid, bus.wb_data, bus.in_ready, !is_gpr, is_gpr, exp_data);
      end
    end
    bus.fpr_wb_ready = !is_gpr; bus.gpr_wb_ready = is_gpr;
    step();
    bus.fpr_wb_ready = 0; bus.gpr_wb_ready = 0;
    checks++;
    if (bus.fpr_wb_valid !== 1'b0 || bus.gpr_wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL wb_release: fpr=%b gpr=%b ready=%b required 0 0 1", bus.fpr_wb_valid, bus.gpr_wb_valid, bus.in_ready);
    end
    $display("txn op_idx=%0d tag=%0d lat=%0d stall=%0d data=%h flags=%b", idx, tag, lat, stall, bus.wb_data, bus.sflags_acc);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_l = 1;
    step(); step();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b required 0", bus.in_ready);
    end
    checks++;
    if ({bus.core_req, bus.core_flush, bus.fpr_wb_valid, bus.gpr_wb_valid, bus.illegal_op, bus.timeout_err,
         bus.sflags_acc, bus.wb_data, bus.wb_tag, bus.core_op, bus.core_a, bus.core_b, bus.core_c,
         bus.core_int, bus.core_rnd} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero, required all 0");
    end
    rst_l = 0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.core_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b req=%b required 1 0", bus.in_ready, bus.core_req);
    end
    exp_flags = 5'd0;
    $display("txn reset done");
  endtask

  task automatic test_fadd();
    run_op(24'h000001, 3'b011, 3'd0, 5'd7, 32'h1234_ABCD, 16'h3F80, 16'h4000, 16'h5555,
           3, 16'h4040, 32'h0, 5'd0, 0, 0);
  endtask

  task automatic test_fle_stall();
    run_op(24'h000800, 3'b011, 3'd1, 5'd19, 32'h0, 16'h3F80, 16'h4000, 16'h0,
           2, 16'hBEEF, 32'h1, 5'd0, 4, 0);
  endtask

  task automatic test_illegal();
    logic [23:0] bad [3];
    bad[0] = 24'h000003; bad[1] = 24'h800000; bad[2] = 24'h000000;
    for (int k = 0; k < 3; k++) begin
      bus.in_op = bad[k]; bus.in_ctrl = 3'b001; bus.in_valid = 1;
      step();
      bus.in_valid = 0;
      checks++;
      if (bus.illegal_op !== 1'b1 || bus.core_req !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL illegal_pulse: op=%h illegal=%b req=%b ready=%b required 1 0 1",
                 bad[k], bus.illegal_op, bus.core_req, bus.in_ready);
      end
      step();
      checks++;
      if (bus.illegal_op !== 1'b0 || bus.core_req !== 1'b0) begin
        failures++;
        $display("FAIL illegal_clear: illegal=%b req=%b required 0 0", bus.illegal_op, bus.core_req);
      end
      $display("txn illegal op=%h", bad[k]);
    end
  endtask

  task automatic test_timeout();
    bus.in_op = 24'h000004; bus.in_ctrl = 3'b111; bus.in_tag = 5'd3; bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    checks++;
    if (bus.core_req !== 1'b1) begin
      failures++;
      $display("FAIL timeout_issue: req=%b required 1", bus.core_req);
    end
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      checks++;
      if (bus.core_flush !== 1'b0 || bus.timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early: cycle=%0d flush=%b err=%b required 0 0", i, bus.core_flush, bus.timeout_err);
      end
    end
    step();
    checks++;
    if (bus.core_flush !== 1'b1 || bus.timeout_err !== 1'b1 || bus.in_ready !== 1'b1 ||
        bus.fpr_wb_valid !== 1'b0 || bus.gpr_wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: flush=%b err=%b ready=%b fpr=%b gpr=%b required 1 1 1 0 0",
               bus.core_flush, bus.timeout_err, bus.in_ready, bus.fpr_wb_valid, bus.gpr_wb_valid);
    end
    step();
    checks++;
    if (bus.core_flush !== 1'b0 || bus.timeout_err !== 1'b0 || bus.sflags_acc !== exp_flags) begin
      failures++;
      $display("FAIL timeout_after: flush=%b err=%b flags=%b required 0 0 %b",
               bus.core_flush, bus.timeout_err, bus.sflags_acc, exp_flags);
    end
    $display("txn timeout");
    run_op(24'h000010, 3'b001, 3'd2, 5'd9, 32'h0, 16'h1111, 16'h2222, 16'h3333,
           1, 16'h7777, 32'h0, 5'd0, 0, 0);
  endtask

  task automatic test_flags();
    bus.sflags_clr = 1;
    step();
    bus.sflags_clr = 0;
    exp_flags = 5'd0;
    checks++;
    if (bus.sflags_acc !== 5'd0) begin
      failures++;
      $display("FAIL flags_clear: got %b required 00000", bus.sflags_acc);
    end
    run_op(24'h000002, 3'b011, 3'd0, 5'd1, 32'h0, 16'h1, 16'h2, 16'h0, 1, 16'h3, 32'h0, 5'b00001, 0, 0);
    run_op(24'h000200, 3'b001, 3'd0, 5'd2, 32'h0, 16'h1, 16'h2, 16'h0, 2, 16'h3, 32'h5, 5'b10000, 0, 0);
    checks++;
    if (bus.sflags_acc !== 5'b10001) begin
      failures++;
      $display("FAIL flags_accum: got %b required 10001", bus.sflags_acc);
    end
    run_op(24'h000008, 3'b011, 3'd0, 5'd3, 32'h0, 16'h1, 16'h2, 16'h0, 0, 16'h4, 32'h0, 5'b00100, 1, 1);
    checks++;
    if (bus.sflags_acc !== 5'b00100) begin
      failures++;
      $display("FAIL flags_set_beats_clear: got %b required 00100", bus.sflags_acc);
    end
  endtask

  task automatic test_random();
    logic [23:0] op;
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = int'($urandom_range(21, 0));
      op = '0;
      op[idx] = 1'b1;
      op[23:22] = 2'($urandom);
      run_op(op, 3'($urandom), 3'($urandom), 5'($urandom), $urandom, 16'($urandom), 16'($urandom),
             16'($urandom), int'($urandom_range(5, 0)), 16'($urandom), $urandom, 5'($urandom),
             int'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0));
    end
  endtask

  task automatic test_reset_mid();
    bus.in_op = 24'h000001; bus.in_ctrl = 3'b011; bus.in_tag = 5'd21; bus.fs1 = 16'hAAAA; bus.in_valid = 1;
    step();
    bus.in_valid = 0;
    step(); step();
    #2 rst_l = 1;
    #1;
    checks++;
    if ({bus.in_ready, bus.core_req, bus.core_flush, bus.fpr_wb_valid, bus.gpr_wb_valid, bus.illegal_op,
         bus.timeout_err, bus.sflags_acc, bus.wb_data, bus.wb_tag, bus.core_op, bus.core_a} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: op=%h a=%h ready=%b required all 0", bus.core_op, bus.core_a, bus.in_ready);
    end
    step();
    rst_l = 0;
    exp_flags = 5'd0;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_release: ready=%b required 1", bus.in_ready);
    end
    bus.core_done = 1; bus.core_res = 16'h1234; bus.core_flags = 5'b11111; bus.fpr_wb_ready = 1;
    step();
    bus.core_done = 0; bus.core_flags = '0; bus.fpr_wb_ready = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.fpr_wb_valid !== 1'b0 || bus.gpr_wb_valid !== 1'b0 || bus.sflags_acc !== 5'd0 ||
          bus.core_req !== 1'b0) begin
        failures++;
        $display("FAIL late_done: fpr=%b gpr=%b flags=%b req=%b required 0 0 00000 0",
                 bus.fpr_wb_valid, bus.gpr_wb_valid, bus.sflags_acc, bus.core_req);
      end
      step();
    end
    $display("txn reset mid-op");
    run_op(24'h004000, 3'b000, 3'd4, 5'd30, 32'hCAFE_F00D, 16'h0, 16'h0, 16'h0,
           0, 16'h0, 32'hDEAD_BEEF, 5'b01000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fle_stall();
    test_illegal();
    test_timeout();
    test_flags();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
